// File: rtl/hash_table.sv
// Shared types for the hash-table command path: commands, results, shadow
// entries and the initiator FSM state.
package hash_table;

  typedef enum logic [1:0] {
    OP_INSERT = 2'd0,
    OP_LOOKUP = 2'd1,
    OP_DELETE = 2'd2,
    OP_NOP    = 2'd3
  } ht_opcode_t;

  typedef struct packed {
    ht_opcode_t  opcode;
    logic [31:0] key;
    logic [31:0] value;
  } ht_command_t;

  typedef struct packed {
    ht_command_t cmd;
    logic        hit;
    logic [31:0] value;
  } ht_result_t;

  // Only the fields the order check compares are kept per in-flight command.
  typedef struct packed {
    ht_opcode_t  opcode;
    logic [31:0] key;
  } ht_shadow_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2,
    TIMEOUT = 2'd3
  } ht_init_state_t;

endpackage

// File: rtl/ht_cmd_if.sv
// Command channel into the hash table (valid/ready).
interface ht_cmd_if;
  import hash_table::*;
  logic        valid;
  logic        ready;
  ht_command_t cmd;
  modport master (output valid, output cmd, input ready);
  modport slave  (input valid, input cmd, output ready);
endinterface

// File: rtl/ht_res_if.sv
// Result channel out of the hash table (valid/ready).
interface ht_res_if;
  import hash_table::*;
  logic       valid;
  logic       ready;
  ht_result_t result;
  modport master (output valid, output result, input ready);
  modport slave  (input valid, input result, output ready);
endinterface

// File: rtl/ht_cmd_shadow_fifo.sv
// Shadow FIFO of issued opcode/key pairs; push and pop may coincide when full.
module ht_cmd_shadow_fifo
  import hash_table::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clr_i,
  input  logic       push_i,
  input  ht_shadow_t din_i,
  input  logic       pop_i,
  output ht_shadow_t head_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  ht_shadow_t    mem_q [DEPTH];
  ht_shadow_t    mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);
  assign head_o  = mem_q[rptr_q];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = din_i;
        wptr_d        = ptr_inc(wptr_q);
      end
      if (do_pop) rptr_d = ptr_inc(rptr_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) mem_q <= mem_d;

endmodule

// File: rtl/ht_cmd_initiator.sv
// Host-to-hash-table command initiator: outstanding tracking, drain, watchdog.
// Define HT_CMD_INITIATOR_CHECK_EN to build in the shadow FIFO and order check.
module ht_cmd_initiator
  import hash_table::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  ht_command_t                        req_cmd_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  ht_cmd_if.master                           ht_cmd_out,
  ht_res_if.slave                            ht_res_in,
  output ht_result_t                         res_o,
  output logic                               res_valid_o,
  input  logic                               res_ready_i,
  input  logic                               flush_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                               idle_o,
  output logic                               timeout_o,
  output logic [15:0]                        order_err_cnt_o
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  ht_init_state_t state_q, state_d;
  logic [OW-1:0]  out_q, out_d;
  logic [WW-1:0]  wdog_q, wdog_d;
  logic           tmo_q, tmo_d;
  logic           can_issue, cmd_hs, res_hs, stray, clr, wdog_inc, tmo_hit;

  // Reset gates issue so nothing leaves while rst_n_i is low.
  assign can_issue = rst_n_i & (state_q == RUN) & (out_q < OW'(MAX_OUTSTANDING)) & ~flush_i;

  assign ht_cmd_out.cmd   = req_cmd_i;
  assign ht_cmd_out.valid = req_valid_i & can_issue;
  assign req_ready_o      = ht_cmd_out.ready & can_issue;

  assign res_o           = ht_res_in.result;
  assign res_valid_o     = ht_res_in.valid;
  assign ht_res_in.ready = res_ready_i;

  assign cmd_hs   = req_valid_i & req_ready_o;
  assign res_hs   = ht_res_in.valid & res_ready_i;
  assign stray    = res_hs & (out_q == '0);
  assign clr      = (state_q == TIMEOUT) & flush_i;
  assign wdog_inc = (out_q != '0) & ~res_hs;
  assign tmo_hit  = ((state_q == RUN) | (state_q == DRAIN)) & wdog_inc &
                    (wdog_q == WW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    out_d  = out_q;
    wdog_d = wdog_q;
    if (clr) out_d = '0;
    else if (cmd_hs & ~res_hs) out_d = out_q + 1'b1;
    else if (~cmd_hs & res_hs & ~stray) out_d = out_q - 1'b1;
    if (clr | ~wdog_inc) wdog_d = '0;
    else if (state_q != TIMEOUT) wdog_d = wdog_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i & ~flush_i) state_d = RUN;
      RUN:     if (tmo_hit) state_d = TIMEOUT;
               else if (flush_i) state_d = DRAIN;
      DRAIN:   if (tmo_hit) state_d = TIMEOUT;
               else if (out_d == '0) state_d = IDLE;
      TIMEOUT: if (flush_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tmo_d = tmo_q | tmo_hit;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      out_q   <= '0;
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
    end
  end

  assign outstanding_o = out_q;
  assign idle_o        = (state_q == IDLE) & (out_q == '0);
  assign timeout_o     = tmo_q;

`ifdef HT_CMD_INITIATOR_CHECK_EN
  ht_shadow_t  head, cmd_sh, res_sh;
  logic        order_err;
  logic [15:0] err_q, err_d;

  assign cmd_sh = '{opcode: req_cmd_i.opcode, key: req_cmd_i.key};
  assign res_sh = '{opcode: ht_res_in.result.cmd.opcode, key: ht_res_in.result.cmd.key};

  // A stray result paired with a same-cycle issue cancels out: no push, no pop.
  ht_cmd_shadow_fifo #(.DEPTH(MAX_OUTSTANDING)) u_shadow (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr),
    .push_i  (cmd_hs & ~stray),
    .din_i   (cmd_sh),
    .pop_i   (res_hs & ~stray),
    .head_o  (head)
  );

  assign order_err = stray | (res_hs & (head != res_sh));

  always_comb begin
    err_d = err_q;
    if (order_err && err_q != 16'hFFFF) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) err_q <= '0;
    else          err_q <= err_d;
  end

  assign order_err_cnt_o = err_q;
`else
  assign order_err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ht_cmd_initiator.sv
// Directed bench for ht_cmd_initiator with a queue scoreboard on both channels.
module tb_ht_cmd_initiator;
  import hash_table::*;

`ifdef HT_CMD_INITIATOR_CHECK_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  ht_command_t req_cmd;
  logic        req_valid;
  logic        req_ready;
  ht_result_t  res_out;
  logic        res_valid;
  logic        res_ready;
  logic        flush;
  logic [3:0]  outstanding;
  logic        idle;
  logic        timeout;
  logic [15:0] err_cnt;

  ht_cmd_if cmd_if();
  ht_res_if res_if();

  always #5 clk = ~clk;

  ht_cmd_initiator #(.MAX_OUTSTANDING(8), .TIMEOUT_CYCLES(16)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .req_cmd_i       (req_cmd),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .ht_cmd_out      (cmd_if),
    .ht_res_in       (res_if),
    .res_o           (res_out),
    .res_valid_o     (res_valid),
    .res_ready_i     (res_ready),
    .flush_i         (flush),
    .outstanding_o   (outstanding),
    .idle_o          (idle),
    .timeout_o       (timeout),
    .order_err_cnt_o (err_cnt)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  ht_command_t exp_cmd_q[$];
  ht_result_t  exp_res_q[$];
  ht_command_t e_cmd;
  ht_result_t  e_res;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake about to happen must match the next expectation.
  always @(negedge clk) begin
    if (cmd_if.valid && cmd_if.ready) begin
      n_chk++;
      if (exp_cmd_q.size() == 0) begin
        n_fail++;
        $display("FAIL cmd_unexpected: got %0h expected none", cmd_if.cmd);
      end else begin
        e_cmd = exp_cmd_q.pop_front();
        if (cmd_if.cmd !== e_cmd) begin
          n_fail++;
          $display("FAIL cmd_data: got %0h expected %0h", cmd_if.cmd, e_cmd);
        end
      end
    end
    if (res_valid && res_ready) begin
      chk("res_ready_pass", {31'd0, res_if.ready}, 32'd1);
      n_chk++;
      if (exp_res_q.size() == 0) begin
        n_fail++;
        $display("FAIL res_unexpected: got %0h expected none", res_out);
      end else begin
        e_res = exp_res_q.pop_front();
        if (res_out !== e_res) begin
          n_fail++;
          $display("FAIL res_data: got %0h expected %0h", res_out, e_res);
        end
      end
    end
  end

  function automatic ht_command_t mk(ht_opcode_t op, logic [31:0] k);
    ht_command_t c;
    c.opcode = op;
    c.key    = k;
    c.value  = k * 3;
    return c;
  endfunction

  function automatic ht_result_t mkres(ht_opcode_t op, logic [31:0] k);
    ht_result_t r;
    r.cmd   = mk(op, k);
    r.hit   = k[0];
    r.value = k ^ 32'hA5A5_0000;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(ht_command_t c);
    bit done;
    done      = 1'b0;
    req_cmd   = c;
    req_valid = 1'b1;
    exp_cmd_q.push_back(c);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready) begin
        done = 1'b1;
        tick();
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    if (!done) chk("issue_wait", 32'd0, 32'd1);
  endtask

  task automatic ret(ht_opcode_t op, logic [31:0] k);
    res_if.result = mkres(op, k);
    res_if.valid  = 1'b1;
    exp_res_q.push_back(res_if.result);
    tick();
    res_if.valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; flush = 1'b0; res_ready = 1'b1;
    cmd_if.ready = 1'b1; res_if.valid = 1'b0; res_if.result = '0;
    tick();
    req_valid = 1'b1;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_cmd_valid", {31'd0, cmd_if.valid}, 32'd0);
    req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_outstanding", {28'd0, outstanding}, 32'd0);
    chk("reset_idle", {31'd0, idle}, 32'd1);
    chk("reset_timeout", {31'd0, timeout}, 32'd0);
    chk("reset_err", {16'd0, err_cnt}, 32'd0);

    // Fill to the limit with results held back
    req_cmd = mk(OP_INSERT, 1); req_valid = 1'b1;
    #1;
    chk("idle_no_ready", {31'd0, req_ready}, 32'd0);
    for (int k = 1; k <= 8; k++) issue(mk(OP_INSERT, k));
    chk("full_outstanding", {28'd0, outstanding}, 32'd8);
    req_cmd = mk(OP_INSERT, 9); req_valid = 1'b1;
    #1;
    chk("full_ready", {31'd0, req_ready}, 32'd0);
    chk("full_valid", {31'd0, cmd_if.valid}, 32'd0);
    req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) ret(OP_INSERT, k);
    chk("drop_to_3", {28'd0, outstanding}, 32'd3);

    // Simultaneous issue and result at 3 outstanding
    req_cmd = mk(OP_LOOKUP, 9); req_valid = 1'b1;
    exp_cmd_q.push_back(req_cmd);
    res_if.result = mkres(OP_INSERT, 6); res_if.valid = 1'b1;
    exp_res_q.push_back(res_if.result);
    #1;
    chk("both_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0; res_if.valid = 1'b0;
    chk("both_outstanding", {28'd0, outstanding}, 32'd3);
    ret(OP_INSERT, 7); ret(OP_INSERT, 8); ret(OP_LOOKUP, 9);
    chk("empty_outstanding", {28'd0, outstanding}, 32'd0);
    chk("inorder_err", {16'd0, err_cnt}, 32'd0);
    chk("run_not_idle", {31'd0, idle}, 32'd0);

    // Swapped result order
    issue(mk(OP_LOOKUP, 32'h10));
    issue(mk(OP_LOOKUP, 32'h20));
    ret(OP_LOOKUP, 32'h20);
    ret(OP_LOOKUP, 32'h10);
    chk("swap_err", {16'd0, err_cnt}, 32'(2 * CE));
    chk("swap_outstanding", {28'd0, outstanding}, 32'd0);

    // Drain with 5 outstanding
    for (int k = 0; k < 5; k++) issue(mk(OP_DELETE, 32'h30 + k));
    chk("drain_outstanding", {28'd0, outstanding}, 32'd5);
    flush = 1'b1; req_cmd = mk(OP_INSERT, 32'h99); req_valid = 1'b1;
    #1;
    chk("flush_ready", {31'd0, req_ready}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("drain_ready", {31'd0, req_ready}, 32'd0);
    chk("drain_not_idle", {31'd0, idle}, 32'd0);
    for (int k = 0; k < 4; k++) ret(OP_DELETE, 32'h30 + k);
    req_valid = 1'b0;
    ret(OP_DELETE, 32'h34);
    chk("drain_idle", {31'd0, idle}, 32'd1);
    chk("drain_zero", {28'd0, outstanding}, 32'd0);
    chk("drain_err", {16'd0, err_cnt}, 32'(2 * CE));

    // Watchdog: one command, no result
    issue(mk(OP_INSERT, 32'h50));
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_cycle15", {31'd0, timeout}, 32'd0);
    tick();
    chk("tmo_cycle16", {31'd0, timeout}, 32'd1);
    req_cmd = mk(OP_INSERT, 32'h51); req_valid = 1'b1;
    #1;
    chk("tmo_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    chk("tmo_outstanding", {28'd0, outstanding}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("tmo_flush_idle", {31'd0, idle}, 32'd1);
    chk("tmo_flush_zero", {28'd0, outstanding}, 32'd0);
    chk("tmo_sticky", {31'd0, timeout}, 32'd1);

    // Reset mid-flight, then a late result
    for (int k = 0; k < 4; k++) issue(mk(OP_INSERT, 32'h40 + k));
    chk("pre_rst_outstanding", {28'd0, outstanding}, 32'd4);
    req_cmd = mk(OP_INSERT, 32'h44); req_valid = 1'b1; rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_valid", {31'd0, cmd_if.valid}, 32'd0);
    tick();
    rst_n = 1'b1; req_valid = 1'b0;
    chk("post_rst_outstanding", {28'd0, outstanding}, 32'd0);
    chk("post_rst_idle", {31'd0, idle}, 32'd1);
    chk("post_rst_timeout", {31'd0, timeout}, 32'd0);
    chk("post_rst_err", {16'd0, err_cnt}, 32'd0);
    ret(OP_INSERT, 32'h40);
    chk("late_outstanding", {28'd0, outstanding}, 32'd0);
    chk("late_err", {16'd0, err_cnt}, 32'(CE));

    @(negedge clk);
    chk("cmd_queue_empty", 32'(exp_cmd_q.size()), 32'd0);
    chk("res_queue_empty", 32'(exp_res_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ht_cmd_initiator.md
HT_CMD_INITIATOR -- requirements
Module: ht_cmd_initiator

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 8, SHALL set the maximum number of commands issued without a returned result (range 1..64).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the number of no-progress cycles that trigger a timeout (range 2..2^20).
REQ-003 Port clk_i, input, 1, SHALL be the single clock; all logic is rising-edge.
REQ-004 Port rst_n_i, input, 1, SHALL be the reset: synchronous, active-low.
REQ-005 Port req_cmd_i, input, ht_command_t, SHALL be the host command.
REQ-006 Ports req_valid_i (input, 1) and req_ready_o (output, 1) SHALL form the host command valid/ready handshake.
REQ-007 Port ht_cmd_out, ht_cmd_if.master, SHALL drive commands into the hash table.
REQ-008 Port ht_res_in, ht_res_if.slave, SHALL receive hash table results.
REQ-009 Ports res_o (output, ht_result_t), res_valid_o (output, 1) and res_ready_i (input, 1) SHALL return results to the host.
REQ-010 Port flush_i, input, 1, SHALL request a drain: stop issuing and wait for all outstanding results.
REQ-011 Port outstanding_o, output, $clog2(MAX_OUTSTANDING+1), SHALL report the in-flight command count.
REQ-012 Port idle_o, output, 1, SHALL be high when the state is IDLE and outstanding_o is 0.
REQ-013 Port timeout_o, output, 1, SHALL be a sticky timeout flag.
REQ-014 Port order_err_cnt_o, output, 16, SHALL count result/command mismatches, saturating at 0xFFFF.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN, DRAIN and TIMEOUT.
REQ-016 IDLE→RUN SHALL occur on req_valid_i=1 with flush_i=0.
REQ-017 RUN→DRAIN SHALL occur on flush_i=1.
REQ-018 DRAIN→IDLE SHALL occur when outstanding reaches 0.
REQ-019 RUN or DRAIN→TIMEOUT SHALL occur when the watchdog reaches TIMEOUT_CYCLES.
REQ-020 TIMEOUT→IDLE SHALL occur only on flush_i=1, which also zeroes outstanding, the watchdog and the shadow FIFO.
REQ-021 can_issue SHALL be (state==RUN) and (outstanding < MAX_OUTSTANDING) and (flush_i==0).
REQ-022 The issue path SHALL be combinational: ht_cmd_out.cmd=req_cmd_i; ht_cmd_out.valid=req_valid_i & can_issue; req_ready_o=ht_cmd_out.ready & can_issue.
REQ-023 The command issued in the IDLE→RUN cycle SHALL be accepted no earlier than the following cycle (req_ready_o=0 in IDLE).
REQ-024 The result path SHALL be pass-through: res_o=ht_res_in.result; res_valid_o=ht_res_in.valid; ht_res_in.ready=res_ready_i.
REQ-025 Outstanding SHALL increment on a command handshake and decrement on a result handshake.
REQ-026 Outstanding SHALL be unchanged when both handshakes occur in the same cycle.
REQ-027 A result handshake while outstanding==0 SHALL leave outstanding at 0, increment order_err_cnt_o and be accepted.
REQ-028 The watchdog SHALL clear on a result handshake or while outstanding==0, and SHALL otherwise increment each cycle.
REQ-029 timeout_o SHALL set on entry to TIMEOUT and clear only on reset.
REQ-030 In TIMEOUT, req_ready_o SHALL be 0 and results SHALL still pass through.
REQ-031 Results SHALL be assumed in command order; each result handshake SHALL pop one shadow entry.
REQ-032 A result whose result.cmd.opcode or result.cmd.key differs from the popped entry SHALL increment order_err_cnt_o.

Reset
REQ-033 On rst_n_i=0 at a clock edge, the block SHALL set state=IDLE, outstanding_o=0, watchdog=0, timeout_o=0, order_err_cnt_o=0, and empty the shadow FIFO.
REQ-034 During reset, req_ready_o and ht_cmd_out.valid SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL discard in-flight tracking; results arriving after reset SHALL be handled per REQ-027.

Configuration
REQ-036 With HT_CMD_INITIATOR_CHECK_EN defined, the shadow FIFO and the order check (REQ-031, REQ-032) SHALL be compiled in.
REQ-037 Without HT_CMD_INITIATOR_CHECK_EN, the shadow FIFO SHALL be absent, order_err_cnt_o SHALL be tied to 0, and REQ-027 SHALL still clamp outstanding without counting.

Structure
REQ-038 ht_command_t, ht_result_t and the FSM state enum ht_init_state_t SHALL reside in package hash_table.
REQ-039 The shadow FIFO SHALL be sub-module ht_cmd_shadow_fifo: depth MAX_OUTSTANDING, stores opcode and key, synchronous push/pop, simultaneous push and pop allowed when full.

Verification
REQ-040 Issue 8 inserts with MAX_OUTSTANDING=8 and ht_res_in.valid held 0 → 8 handshakes, outstanding_o=8, req_ready_o=0 on the 9th command.
REQ-041 Command and result handshakes in the same cycle at outstanding=3 → outstanding_o stays 3.
REQ-042 Issue keys 0x10 then 0x20, and return results in order 0x20 then 0x10 (CHECK_EN defined) → order_err_cnt_o=2.
REQ-043 TIMEOUT_CYCLES=16, 1 command issued and no result returned → timeout_o=1 in the 16th cycle after issue, req_ready_o=0; then flush_i pulse → IDLE, outstanding_o=0, timeout_o stays 1.
REQ-044 flush_i with 5 outstanding → no further issue; idle_o=1 the cycle after the 5th result handshake.
REQ-045 rst_n_i low for 1 cycle with 4 outstanding → all counters 0, state IDLE; a late result → outstanding_o stays 0, order_err_cnt_o=1 (0 without CHECK_EN).
